// File: rtl/cnn_conv_lane_feeder_pkg.sv
// Shared constants, lane enum and sizing helpers for the 4-lane convolution feeder.
// Module-level parameters are resolved through the helper functions below.
package cnn_conv_lane_feeder_pkg;

    localparam int LANES     = 4;
    localparam int BUF_BANKS = LANES - 1;

    typedef enum logic [1:0] {
        LANE1 = 2'd0,
        LANE2 = 2'd1,
        LANE3 = 2'd2,
        LANE4 = 2'd3
    } lane_e;

    // Bits needed for a counter that holds 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ch_per_lane_f(input int ch_in);
        return ch_in / LANES;
    endfunction

    function automatic int w_per_lane_f(input int ch_in, input int ch_out, input int kernel);
        return ch_out * ch_per_lane_f(ch_in) * kernel * kernel;
    endfunction

    // Values at the default configuration (64 in / 64 out, 3x3, 612x612).
    localparam int DEF_CH_PER_LANE = ch_per_lane_f(64);
    localparam int DEF_W_PER_LANE  = w_per_lane_f(64, 64, 3);
    localparam int DEF_PIX_TOTAL   = 612 * 612;
    localparam int DEF_CH_W        = cnt_width(64);
    localparam int DEF_PIX_W       = cnt_width(DEF_PIX_TOTAL);
    localparam int DEF_W_CNT_W     = cnt_width(LANES * DEF_W_PER_LANE + 1);

endpackage

// File: rtl/cnn_lane_ch_buffer.sv
// Holds lanes 1..3 of the current pixel until the lane-4 channels arrive.
// One write port (bank + address), one shared combinational read address.
module cnn_lane_ch_buffer
    import cnn_conv_lane_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  lane_e                 wr_bank,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data [BUF_BANKS]
);

    for (genvar b = 0; b < BUF_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == lane_e'(b))) begin
                mem_q[wr_addr] <= wr_data;
            end
        end

        // Read is combinational; the top registers it alongside the lane-4 beat.
        assign rd_data[b] = mem_q[rd_addr];
    end

endmodule

// File: rtl/cnn_conv_lane_feeder.sv
// Splits a channel-sequential pixel stream into four beat-aligned lane streams
// and routes a block-ordered weight stream to the four lane weight ports.
module cnn_conv_lane_feeder
    import cnn_conv_lane_feeder_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 612,
    parameter int IMAGE_HEIGHT    = 612,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int KERNEL          = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  valid_out1,
    output logic                  valid_out2,
    output logic                  valid_out3,
    output logic                  valid_out4,
    output logic [DATA_WIDTH-1:0] pxl_out1,
    output logic [DATA_WIDTH-1:0] pxl_out2,
    output logic [DATA_WIDTH-1:0] pxl_out3,
    output logic [DATA_WIDTH-1:0] pxl_out4,
    output logic                  valid_weight_out1,
    output logic                  valid_weight_out2,
    output logic                  valid_weight_out3,
    output logic                  valid_weight_out4,
    output logic [DATA_WIDTH-1:0] weight_out1,
    output logic [DATA_WIDTH-1:0] weight_out2,
    output logic [DATA_WIDTH-1:0] weight_out3,
    output logic [DATA_WIDTH-1:0] weight_out4,
    output logic                  weight_done,
    output logic                  frame_done
);

    localparam int CH_PER_LANE = ch_per_lane_f(CHANNEL_NUM_IN);
    localparam int W_PER_LANE  = w_per_lane_f(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
    localparam int PIX_TOTAL   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int W_TOTAL     = LANES * W_PER_LANE;
    localparam int AW          = cnt_width(CH_PER_LANE);
    localparam int PW          = cnt_width(PIX_TOTAL);
    localparam int WW          = cnt_width(W_TOTAL + 1);
    localparam int WIW         = cnt_width(W_PER_LANE);

    // ch_cnt is kept split as lane_sel * CH_PER_LANE + ch_addr, which gives
    // the buffer bank and address directly without a divider.
    lane_e                 lane_sel_q, lane_sel_d;
    logic [AW-1:0]         ch_addr_q, ch_addr_d;
    logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] pxl_q [LANES];
    logic [DATA_WIDTH-1:0] pxl_d [LANES];

    logic                  buf_wr_en;
    logic [DATA_WIDTH-1:0] buf_rd_data [BUF_BANKS];

    logic [WW-1:0]         w_cnt_q, w_cnt_d;
    lane_e                 w_lane_q, w_lane_d;
    logic [WIW-1:0]        w_idx_q, w_idx_d;
    logic [LANES-1:0]      w_valid_q, w_valid_d;
    logic [DATA_WIDTH-1:0] w_out_q [LANES];
    logic [DATA_WIDTH-1:0] w_out_d [LANES];
    logic                  weight_done_q, weight_done_d;
    logic                  w_full;

    cnn_lane_ch_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (CH_PER_LANE),
        .AW        (AW)
    ) u_buf (
        .clk    (clk),
        .wr_en  (buf_wr_en),
        .wr_bank(lane_sel_q),
        .wr_addr(ch_addr_q),
        .wr_data(pxl_in),
        .rd_addr(ch_addr_q),
        .rd_data(buf_rd_data)
    );

    // Pixel path: buffer lanes 1..3, emit all four lanes on each lane-4 beat.
    always_comb begin
        lane_sel_d   = lane_sel_q;
        ch_addr_d    = ch_addr_q;
        pix_cnt_d    = pix_cnt_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        buf_wr_en    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            pxl_d[k] = pxl_q[k];
        end

        if (valid_in) begin
            if (lane_sel_q != LANE4) begin
                buf_wr_en = 1'b1;
            end else begin
                valid_out_d = 1'b1;
                pxl_d[0]    = buf_rd_data[0];
                pxl_d[1]    = buf_rd_data[1];
                pxl_d[2]    = buf_rd_data[2];
                pxl_d[3]    = pxl_in;
            end

            if (ch_addr_q == AW'(CH_PER_LANE - 1)) begin
                ch_addr_d  = '0;
                lane_sel_d = lane_e'(lane_sel_q + 2'd1);
                if (lane_sel_q == LANE4) begin
                    if (pix_cnt_q == PW'(PIX_TOTAL - 1)) begin
                        pix_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end else begin
                ch_addr_d = ch_addr_q + 1'b1;
            end
        end
    end

    // Weight path: w_full blocks further weights one cycle before weight_done shows.
    assign w_full = (w_cnt_q == WW'(W_TOTAL));

    always_comb begin
        w_cnt_d       = w_cnt_q;
        w_lane_d      = w_lane_q;
        w_idx_d       = w_idx_q;
        w_valid_d     = '0;
        weight_done_d = weight_done_q | w_full;
        for (int k = 0; k < LANES; k++) begin
            w_out_d[k] = w_out_q[k];
        end

        if (valid_weight_in && !w_full) begin
            w_valid_d[w_lane_q] = 1'b1;
            w_out_d[w_lane_q]   = weight_in;
            w_cnt_d             = w_cnt_q + 1'b1;
            if (w_idx_q == WIW'(W_PER_LANE - 1)) begin
                w_idx_d  = '0;
                w_lane_d = lane_e'(w_lane_q + 2'd1);
            end else begin
                w_idx_d = w_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_sel_q    <= LANE1;
            ch_addr_q     <= '0;
            pix_cnt_q     <= '0;
            valid_out_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            w_cnt_q       <= '0;
            w_lane_q      <= LANE1;
            w_idx_q       <= '0;
            w_valid_q     <= '0;
            weight_done_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                pxl_q[k]   <= '0;
                w_out_q[k] <= '0;
            end
        end else begin
            lane_sel_q    <= lane_sel_d;
            ch_addr_q     <= ch_addr_d;
            pix_cnt_q     <= pix_cnt_d;
            valid_out_q   <= valid_out_d;
            frame_done_q  <= frame_done_d;
            w_cnt_q       <= w_cnt_d;
            w_lane_q      <= w_lane_d;
            w_idx_q       <= w_idx_d;
            w_valid_q     <= w_valid_d;
            weight_done_q <= weight_done_d;
            for (int k = 0; k < LANES; k++) begin
                pxl_q[k]   <= pxl_d[k];
                w_out_q[k] <= w_out_d[k];
            end
        end
    end

    assign valid_out1        = valid_out_q;
    assign valid_out2        = valid_out_q;
    assign valid_out3        = valid_out_q;
    assign valid_out4        = valid_out_q;
    assign pxl_out1          = pxl_q[0];
    assign pxl_out2          = pxl_q[1];
    assign pxl_out3          = pxl_q[2];
    assign pxl_out4          = pxl_q[3];
    assign valid_weight_out1 = w_valid_q[0];
    assign valid_weight_out2 = w_valid_q[1];
    assign valid_weight_out3 = w_valid_q[2];
    assign valid_weight_out4 = w_valid_q[3];
    assign weight_out1       = w_out_q[0];
    assign weight_out2       = w_out_q[1];
    assign weight_out3       = w_out_q[2];
    assign weight_out4       = w_out_q[3];
    assign weight_done       = weight_done_q;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_cnn_conv_lane_feeder.sv
// Directed bench for cnn_conv_lane_feeder at 2x2 image, 8 input channels,
// 2 output channels, 3x3 kernel (2 channels and 36 weights per lane).
module tb_cnn_conv_lane_feeder;

    localparam int DW  = 32;
    localparam int CPL = 2;
    localparam int WPL = 36;

    typedef struct {
        logic        vin;
        logic [31:0] pin;
        logic        vwin;
        logic [31:0] win;
        logic        ev;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
        logic [31:0] e4;
        logic        efd;
        logic [3:0]  evw;
        logic        ewd;
    } vec_t;

    // Clock and reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          valid_in, valid_weight_in;
    logic [DW-1:0] pxl_in, weight_in;
    logic          valid_out1, valid_out2, valid_out3, valid_out4;
    logic [DW-1:0] pxl_out1, pxl_out2, pxl_out3, pxl_out4;
    logic          valid_weight_out1, valid_weight_out2, valid_weight_out3, valid_weight_out4;
    logic [DW-1:0] weight_out1, weight_out2, weight_out3, weight_out4;
    logic          weight_done, frame_done;

    cnn_conv_lane_feeder #(
        .DATA_WIDTH     (DW),
        .IMAGE_WIDTH    (2),
        .IMAGE_HEIGHT   (2),
        .CHANNEL_NUM_IN (8),
        .CHANNEL_NUM_OUT(2),
        .KERNEL         (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .pxl_in           (pxl_in),
        .valid_weight_in  (valid_weight_in),
        .weight_in        (weight_in),
        .valid_out1       (valid_out1),
        .valid_out2       (valid_out2),
        .valid_out3       (valid_out3),
        .valid_out4       (valid_out4),
        .pxl_out1         (pxl_out1),
        .pxl_out2         (pxl_out2),
        .pxl_out3         (pxl_out3),
        .pxl_out4         (pxl_out4),
        .valid_weight_out1(valid_weight_out1),
        .valid_weight_out2(valid_weight_out2),
        .valid_weight_out3(valid_weight_out3),
        .valid_weight_out4(valid_weight_out4),
        .weight_out1      (weight_out1),
        .weight_out2      (weight_out2),
        .weight_out3      (weight_out3),
        .weight_out4      (weight_out4),
        .weight_done      (weight_done),
        .frame_done       (frame_done)
    );

    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   fd_seen = 0;
    logic cur_wd  = 1'b0;
    vec_t vq[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Row builder: lane expectations are (base+c, base+CPL+c, base+2CPL+c, base+3CPL+c).
    function automatic vec_t mk(input logic vin, input int pin, input logic ev,
                                input int base, input int c, input logic fd);
        vec_t v;
        v.vin  = vin;
        v.pin  = 32'(pin);
        v.vwin = 1'b0;
        v.win  = '0;
        v.ev   = ev;
        v.e1   = 32'(base + c);
        v.e2   = 32'(base + CPL + c);
        v.e3   = 32'(base + 2 * CPL + c);
        v.e4   = 32'(base + 3 * CPL + c);
        v.efd  = fd;
        v.evw  = '0;
        v.ewd  = cur_wd;
        return v;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) vq.push_back(mk(1'b0, 0, 1'b0, 0, 0, 1'b0));
    endtask

    // One pixel of 8 channels, value base+ch, with up to gap_max idle cycles before each beat.
    task automatic add_pixel(input int base, input int gap_max, input bit last_of_frame);
        for (int ch = 0; ch < 4 * CPL; ch++) begin
            add_idle(int'($urandom_range(0, gap_max)));
            vq.push_back(mk(1'b1, base + ch, ch >= 3 * CPL, base, ch - 3 * CPL,
                            last_of_frame && (ch == 4 * CPL - 1)));
        end
    endtask

    task automatic check_row(input vec_t v);
        logic [31:0] wa;
        cmp("valid_out", 32'({valid_out1, valid_out2, valid_out3, valid_out4}), 32'({4{v.ev}}));
        if (v.ev) begin
            cmp("pxl_out1", pxl_out1, v.e1);
            cmp("pxl_out2", pxl_out2, v.e2);
            cmp("pxl_out3", pxl_out3, v.e3);
            cmp("pxl_out4", pxl_out4, v.e4);
        end
        cmp("frame_done", 32'(frame_done), 32'(v.efd));
        if (frame_done) fd_seen++;
        cmp("valid_weight_out",
            32'({valid_weight_out4, valid_weight_out3, valid_weight_out2, valid_weight_out1}),
            32'(v.evw));
        if (v.evw != 4'b0000) begin
            wa = v.evw[0] ? weight_out1 : v.evw[1] ? weight_out2 :
                 v.evw[2] ? weight_out3 : weight_out4;
            cmp("weight_out", wa, v.win);
        end
        cmp("weight_done", 32'(weight_done), 32'(v.ewd));
    endtask

    // Driver: apply one row after a posedge, check its result 1 ns after the next posedge.
    task automatic run_queue();
        while (vq.size() > 0) begin
            vec_t v;
            v = vq.pop_front();
            valid_in        = v.vin;
            pxl_in          = v.pin;
            valid_weight_in = v.vwin;
            weight_in       = v.win;
            @(posedge clk);
            #1;
            check_row(v);
        end
        valid_in        = 1'b0;
        valid_weight_in = 1'b0;
    endtask

    task automatic check_zero();
        cmp("rst_valid_out", 32'({valid_out1, valid_out2, valid_out3, valid_out4}), 32'(0));
        cmp("rst_pxl_out1", pxl_out1, 32'(0));
        cmp("rst_pxl_out2", pxl_out2, 32'(0));
        cmp("rst_pxl_out3", pxl_out3, 32'(0));
        cmp("rst_pxl_out4", pxl_out4, 32'(0));
        cmp("rst_valid_weight_out",
            32'({valid_weight_out1, valid_weight_out2, valid_weight_out3, valid_weight_out4}), 32'(0));
        cmp("rst_weight_out1", weight_out1, 32'(0));
        cmp("rst_weight_out4", weight_out4, 32'(0));
        cmp("rst_weight_done", 32'(weight_done), 32'(0));
        cmp("rst_frame_done", 32'(frame_done), 32'(0));
    endtask

    task automatic do_reset(input bit check);
        reset           = 1'b1;
        valid_in        = 1'b0;
        valid_weight_in = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (check) check_zero();
        end
        reset  = 1'b0;
        cur_wd = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        valid_in        = 1'b0;
        pxl_in          = '0;
        valid_weight_in = 1'b0;
        weight_in       = '0;

        // Single pixel 1..8, then hold check on idle cycles.
        do_reset(1'b1);
        add_pixel(1, 0, 1'b0);
        add_idle(3);
        run_queue();
        cmp("pxl_hold", pxl_out1, 32'd2);

        // Full frame, four pixels back-to-back.
        do_reset(1'b0);
        fd_seen = 0;
        for (int p = 0; p < 4; p++) add_pixel(10 * p, 0, p == 3);
        add_idle(2);
        run_queue();
        cmp("frame_done_count", 32'(fd_seen), 32'd1);

        // Same frame with random valid_in gaps.
        do_reset(1'b0);
        fd_seen = 0;
        for (int p = 0; p < 4; p++) add_pixel(10 * p, 3, p == 3);
        add_idle(2);
        run_queue();
        cmp("frame_done_count_gaps", 32'(fd_seen), 32'd1);

        // Weights 0..143 followed by 5 extras that must be dropped.
        do_reset(1'b0);
        for (int i = 0; i < 4 * WPL; i++) begin
            vec_t v;
            v      = mk(1'b0, 0, 1'b0, 0, 0, 1'b0);
            v.vwin = 1'b1;
            v.win  = 32'(i);
            v.evw  = 4'b0001 << (i / WPL);
            vq.push_back(v);
        end
        cur_wd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vec_t v;
            v      = mk(1'b0, 0, 1'b0, 0, 0, 1'b0);
            v.vwin = 1'b1;
            v.win  = 32'(200 + k);
            vq.push_back(v);
        end
        add_idle(1);
        run_queue();

        // Reset in the middle of a pixel, then a fresh pixel 101..108.
        add_pixel(1, 0, 1'b0);
        for (int ch = 0; ch < 6; ch++) vq.push_back(mk(1'b1, 51 + ch, 1'b0, 0, 0, 1'b0));
        run_queue();
        do_reset(1'b1);
        add_pixel(101, 0, 1'b0);
        add_idle(1);
        run_queue();

        // Pixels and weights active in the same cycles.
        do_reset(1'b0);
        for (int p = 0; p < 3; p++) add_pixel(10 * p, 1, 1'b0);
        for (int r = 0; r < vq.size(); r++) begin
            vq[r].vwin = 1'b1;
            vq[r].win  = 32'(300 + r);
            vq[r].evw  = 4'b0001 << (r / WPL);
        end
        add_idle(1);
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
